// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC, reads a 1-cycle-latency ROM and
// buffers address-tagged instructions for decode behind a valid/ready handshake.
module fetch_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_value,
    output logic [WIDTH-1:0] pc_in,
    output logic             pc_load,
    output logic             pc_inc,
    output logic [WIDTH-1:0] rom_addr,
    output logic             rom_rd,
    input  logic [WIDTH-1:0] rom_data,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] instr_addr,
    output logic             instr_valid,
    input  logic             instr_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [WIDTH-1:0] r_addr [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_inflight;
    logic [WIDTH-1:0] r_tag;

    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic [CW:0]      w_used;
    logic [CW:0]      w_limit;

    assign instr_valid = reset && (r_count != '0);
    assign instr_out   = r_data[r_head];
    assign instr_addr  = r_addr[r_head];

    // A jump flushes the buffer, so it also kills any same-cycle pop and
    // the return of the read that is in flight right now.
    assign w_pop  = reset && !jump && instr_valid && instr_ready;
    assign w_push = reset && !jump && r_inflight;

    // Slots already held plus the outstanding read must leave room; a
    // same-cycle pop frees one so a ready decoder sees one word per cycle.
    assign w_used  = {1'b0, r_count} + (CW+1)'(r_inflight);
    assign w_limit = (CW+1)'(DEPTH) + (CW+1)'(w_pop);
    assign w_issue = reset && !jump && (w_used < w_limit);

    assign rom_addr = pc_value;
    assign rom_rd   = w_issue;
    assign pc_inc   = w_issue;
    assign pc_load  = reset && jump;
    assign pc_in    = pc_load ? jump_target : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_tag      <= '0;
        end else begin
            r_inflight <= w_issue;
            r_tag      <= pc_value;
            if (jump) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push)
                    r_tail <= r_tail + AW'(1);
                if (w_pop)
                    r_head <= r_head + AW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_tail] <= rom_data;
            r_addr[r_tail] <= r_tag;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural PC register and ROM.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [15:0] pc_value;
    logic [15:0] pc_in;
    logic        pc_load;
    logic        pc_inc;
    logic [15:0] rom_addr;
    logic        rom_rd;
    logic [15:0] rom_data;
    logic        jump;
    logic [15:0] jump_target;
    logic [15:0] instr_out;
    logic [15:0] instr_addr;
    logic        instr_valid;
    logic        instr_ready;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.WIDTH(16), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .pc_value(pc_value), .pc_in(pc_in),
        .pc_load(pc_load), .pc_inc(pc_inc), .rom_addr(rom_addr),
        .rom_rd(rom_rd), .rom_data(rom_data), .jump(jump),
        .jump_target(jump_target), .instr_out(instr_out),
        .instr_addr(instr_addr), .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: addr 0..3 -> A000, B001, C002, D003
    function automatic logic [15:0] rom_word(input logic [15:0] a);
        logic [3:0] hi;
        hi = a[3:0] + 4'hA;
        return {hi, a[11:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (!reset)       pc_value <= 16'h0000;
        else if (pc_load) pc_value <= pc_in;
        else if (pc_inc)  pc_value <= pc_value + 16'h0001;
    end

    always_ff @(posedge clk)
        if (rom_rd) rom_data <= rom_word(rom_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        jump  = 1'b0;
        jump_target = 16'h0000;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; jump = 1'b1; jump_target = 16'h1234; instr_ready = 1'b1;
        step(); step();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        total++; if (rom_rd !== 1'b0) begin bad++; $display("FAIL rst_rom_rd got=%b exp=0", rom_rd); end
        total++; if (pc_inc !== 1'b0) begin bad++; $display("FAIL rst_pc_inc got=%b exp=0", pc_inc); end
        total++; if (pc_load !== 1'b0) begin bad++; $display("FAIL rst_pc_load got=%b exp=0", pc_load); end
        total++; if (pc_in !== 16'h0000) begin bad++; $display("FAIL rst_pc_in got=%h exp=0000", pc_in); end
        total++; if (rom_addr !== 16'h0000) begin bad++; $display("FAIL rst_rom_addr got=%h exp=0000", rom_addr); end
        jump = 1'b0;
    endtask

    task automatic test_sequential();
        logic [15:0] exp_d [4];
        exp_d[0] = 16'hA000; exp_d[1] = 16'hB001; exp_d[2] = 16'hC002; exp_d[3] = 16'hD003;
        do_reset();
        instr_ready = 1'b1; reset = 1'b1; #1;
        total++; if (rom_rd !== 1'b1 || rom_addr !== 16'h0000) begin bad++; $display("FAIL seq_c1_issue got rd=%b addr=%h exp rd=1 addr=0000", rom_rd, rom_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL seq_c1_valid got=%b exp=0", instr_valid); end
        step();
        total++; if (rom_rd !== 1'b1 || rom_addr !== 16'h0001 || instr_valid !== 1'b0) begin bad++; $display("FAIL seq_c2 got rd=%b addr=%h v=%b exp rd=1 addr=0001 v=0", rom_rd, rom_addr, instr_valid); end
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (instr_valid !== 1'b1 || instr_addr !== 16'(i) || instr_out !== exp_d[i]) begin
                bad++; $display("FAIL seq_out%0d got v=%b addr=%h data=%h exp v=1 addr=%h data=%h", i, instr_valid, instr_addr, instr_out, 16'(i), exp_d[i]);
            end
            step();
        end
    endtask

    task automatic test_stall();
        do_reset();
        instr_ready = 1'b1; reset = 1'b1;
        step(); step();
        instr_ready = 1'b0; #1;
        total++; if (pc_inc !== 1'b0 || pc_value !== 16'h0002) begin bad++; $display("FAIL stall_c3 got inc=%b pc=%h exp inc=0 pc=0002", pc_inc, pc_value); end
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if (pc_inc !== 1'b0 || pc_value !== 16'h0002 || instr_valid !== 1'b1 || instr_out !== 16'hA000 || instr_addr !== 16'h0000) begin
                bad++; $display("FAIL stall_hold%0d got inc=%b pc=%h v=%b data=%h addr=%h exp inc=0 pc=0002 v=1 data=A000 addr=0000", c, pc_inc, pc_value, instr_valid, instr_out, instr_addr);
            end
        end
        instr_ready = 1'b1; #1;
        total++; if (instr_addr !== 16'h0000 || pc_inc !== 1'b1) begin bad++; $display("FAIL stall_resume got addr=%h inc=%b exp addr=0000 inc=1", instr_addr, pc_inc); end
        step();
        total++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0001 || instr_out !== 16'hB001) begin bad++; $display("FAIL stall_next1 got v=%b addr=%h data=%h exp v=1 addr=0001 data=B001", instr_valid, instr_addr, instr_out); end
        step();
        total++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0002 || instr_out !== 16'hC002) begin bad++; $display("FAIL stall_next2 got v=%b addr=%h data=%h exp v=1 addr=0002 data=C002", instr_valid, instr_addr, instr_out); end
    endtask

    task automatic test_jump();
        do_reset();
        instr_ready = 1'b0; reset = 1'b1;
        step(); step();
        jump = 1'b1; jump_target = 16'h0040; #1;
        total++; if (pc_load !== 1'b1 || pc_in !== 16'h0040 || pc_inc !== 1'b0 || rom_rd !== 1'b0) begin
            bad++; $display("FAIL jump_strobes got load=%b in=%h inc=%b rd=%b exp load=1 in=0040 inc=0 rd=0", pc_load, pc_in, pc_inc, rom_rd);
        end
        step();
        jump = 1'b0; instr_ready = 1'b1; #1;
        total++; if (instr_valid !== 1'b0 || rom_rd !== 1'b1 || rom_addr !== 16'h0040) begin
            bad++; $display("FAIL jump_refetch got v=%b rd=%b addr=%h exp v=0 rd=1 addr=0040", instr_valid, rom_rd, rom_addr);
        end
        step();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL jump_stale got v=%b addr=%h exp v=0", instr_valid, instr_addr); end
        step();
        total++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0040 || instr_out !== rom_word(16'h0040)) begin
            bad++; $display("FAIL jump_first got v=%b addr=%h data=%h exp v=1 addr=0040 data=%h", instr_valid, instr_addr, instr_out, rom_word(16'h0040));
        end
        step();
        total++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0041) begin bad++; $display("FAIL jump_second got v=%b addr=%h exp v=1 addr=0041", instr_valid, instr_addr); end
        // jump with a valid head and ready=1: the head must not be consumed
        jump = 1'b1; jump_target = 16'h0100; #1;
        total++; if (pc_load !== 1'b1 || pc_inc !== 1'b0 || rom_rd !== 1'b0) begin bad++; $display("FAIL jpop_strobes got load=%b inc=%b rd=%b exp load=1 inc=0 rd=0", pc_load, pc_inc, rom_rd); end
        step();
        jump = 1'b0; #1;
        total++; if (instr_valid !== 1'b0 || rom_rd !== 1'b1 || rom_addr !== 16'h0100 || pc_inc !== 1'b1) begin
            bad++; $display("FAIL jpop_after got v=%b rd=%b addr=%h inc=%b exp v=0 rd=1 addr=0100 inc=1", instr_valid, rom_rd, rom_addr, pc_inc);
        end
        step();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL jpop_empty got v=%b exp=0", instr_valid); end
        step();
        total++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0100) begin bad++; $display("FAIL jpop_first got v=%b addr=%h exp v=1 addr=0100", instr_valid, instr_addr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        instr_ready = 1'b1; reset = 1'b1;
        step(); step(); step();
        jump = 1'b1; jump_target = 16'h0200;
        step();
        jump_target = 16'h0300; #1;
        total++; if (pc_load !== 1'b1 || pc_in !== 16'h0300 || rom_rd !== 1'b0) begin
            bad++; $display("FAIL b2b_second got load=%b in=%h rd=%b exp load=1 in=0300 rd=0", pc_load, pc_in, rom_rd);
        end
        step();
        jump = 1'b0; #1;
        total++; if (rom_rd !== 1'b1 || rom_addr !== 16'h0300 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_issue got rd=%b addr=%h v=%b exp rd=1 addr=0300 v=0", rom_rd, rom_addr, instr_valid);
        end
        step();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got v=%b exp=0", instr_valid); end
        step();
        total++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0300 || instr_out !== rom_word(16'h0300)) begin
            bad++; $display("FAIL b2b_first got v=%b addr=%h data=%h exp v=1 addr=0300", instr_valid, instr_addr, instr_out);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_a [4];
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
        do_reset();
        instr_ready = 1'b1; reset = 1'b1; jump = 1'b1; jump_target = 16'hFFFE;
        step();
        jump = 1'b0;
        step(); step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (instr_valid !== 1'b1 || instr_addr !== exp_a[i] || instr_out !== rom_word(exp_a[i])) begin
                bad++; $display("FAIL wrap%0d got v=%b addr=%h data=%h exp v=1 addr=%h data=%h", i, instr_valid, instr_addr, instr_out, exp_a[i], rom_word(exp_a[i]));
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr_ready = 1'b1; reset = 1'b1;
        step(); step(); step();
        total++; if (rom_rd !== 1'b1 || instr_valid !== 1'b1) begin bad++; $display("FAIL rmid_run got rd=%b v=%b exp rd=1 v=1", rom_rd, instr_valid); end
        step();
        reset = 1'b0; jump = 1'b1; jump_target = 16'h0555; #1;
        total++; if (rom_rd !== 1'b0 || pc_inc !== 1'b0 || pc_load !== 1'b0 || pc_in !== 16'h0000 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_strobes got rd=%b inc=%b load=%b in=%h v=%b exp all 0", rom_rd, pc_inc, pc_load, pc_in, instr_valid);
        end
        total++; if (rom_addr !== pc_value) begin bad++; $display("FAIL rmid_rom_addr got=%h exp=%h", rom_addr, pc_value); end
        step();
        reset = 1'b1; jump = 1'b0; #1;
        total++; if (instr_valid !== 1'b0 || rom_rd !== 1'b1 || rom_addr !== 16'h0000) begin
            bad++; $display("FAIL rmid_release got v=%b rd=%b addr=%h exp v=0 rd=1 addr=0000", instr_valid, rom_rd, rom_addr);
        end
        step();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rmid_drop got v=%b addr=%h exp v=0", instr_valid, instr_addr); end
        step();
        total++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0000 || instr_out !== 16'hA000) begin
            bad++; $display("FAIL rmid_first got v=%b addr=%h data=%h exp v=1 addr=0000 data=A000", instr_valid, instr_addr, instr_out);
        end
    endtask

    initial begin
        reset = 1'b0; jump = 1'b0; jump_target = 16'h0000; instr_ready = 1'b0;
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
